// File: rtl/alu_cdb_stage_if.sv
// Operation encoding shared by the RS, this stage and the bench, plus the
// issue/CDB bundle between the reservation station/arbiter and the ALU stage.
package alu_cdb_stage_pkg;
   localparam int OPT_W = 6;

   localparam logic [OPT_W-1:0] OPT_NONE  = 6'd0;
   localparam logic [OPT_W-1:0] OPT_LUI   = 6'd1;
   localparam logic [OPT_W-1:0] OPT_AUIPC = 6'd2;
   localparam logic [OPT_W-1:0] OPT_JAL   = 6'd3;
   localparam logic [OPT_W-1:0] OPT_JALR  = 6'd4;
   localparam logic [OPT_W-1:0] OPT_BEQ   = 6'd5;
   localparam logic [OPT_W-1:0] OPT_BNE   = 6'd6;
   localparam logic [OPT_W-1:0] OPT_BLT   = 6'd7;
   localparam logic [OPT_W-1:0] OPT_BGE   = 6'd8;
   localparam logic [OPT_W-1:0] OPT_BLTU  = 6'd9;
   localparam logic [OPT_W-1:0] OPT_BGEU  = 6'd10;
   localparam logic [OPT_W-1:0] OPT_ADD   = 6'd11;
   localparam logic [OPT_W-1:0] OPT_SUB   = 6'd12;
   localparam logic [OPT_W-1:0] OPT_SLL   = 6'd13;
   localparam logic [OPT_W-1:0] OPT_SLT   = 6'd14;
   localparam logic [OPT_W-1:0] OPT_SLTU  = 6'd15;
   localparam logic [OPT_W-1:0] OPT_XOR   = 6'd16;
   localparam logic [OPT_W-1:0] OPT_SRL   = 6'd17;
   localparam logic [OPT_W-1:0] OPT_SRA   = 6'd18;
   localparam logic [OPT_W-1:0] OPT_OR    = 6'd19;
   localparam logic [OPT_W-1:0] OPT_AND   = 6'd20;
   localparam logic [OPT_W-1:0] OPT_ADDI  = 6'd21;
   localparam logic [OPT_W-1:0] OPT_SLTI  = 6'd22;
   localparam logic [OPT_W-1:0] OPT_SLTIU = 6'd23;
   localparam logic [OPT_W-1:0] OPT_XORI  = 6'd24;
   localparam logic [OPT_W-1:0] OPT_ORI   = 6'd25;
   localparam logic [OPT_W-1:0] OPT_ANDI  = 6'd26;
   localparam logic [OPT_W-1:0] OPT_SLLI  = 6'd27;
   localparam logic [OPT_W-1:0] OPT_SRLI  = 6'd28;
   localparam logic [OPT_W-1:0] OPT_SRAI  = 6'd29;
endpackage

interface alu_cdb_stage_if #(
   parameter int ROB_BIT = 4
);
   import alu_cdb_stage_pkg::*;

   logic                ena;
   logic [OPT_W-1:0]    opt;
   logic [31:0]         val1;
   logic [31:0]         val2;
   logic [31:0]         imm;
   logic [31:0]         pc;
   logic [ROB_BIT-1:0]  rob_idx;
   logic                full;

   logic                gnt;
   logic                valid;
   logic [ROB_BIT-1:0]  src;
   logic [31:0]         val;
   logic                jump;
   logic [31:0]         target;

   modport master (
      output ena, opt, val1, val2, imm, pc, rob_idx, gnt,
      input  full, valid, src, val, jump, target
   );

   modport slave (
      input  ena, opt, val1, val2, imm, pc, rob_idx, gnt,
      output full, valid, src, val, jump, target
   );
endinterface

// File: rtl/alu_cdb_stage.sv
// RV32I integer/branch/jump execution stage with a small result FIFO whose
// head drives the ALU channel of the CDB; flushes on ROB rollback.
module alu_cdb_stage
   import alu_cdb_stage_pkg::*;
#(
   parameter int ROB_BIT   = 4,
   parameter int QUEUE_BIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rdy_i,
   input  logic             alu_rb_i,
   alu_cdb_stage_if.slave   bus_if,
   output logic             alu_ovf_o
);

   localparam int DEPTH  = 1 << QUEUE_BIT;
   localparam int ALMOST = DEPTH - 1;
   localparam logic [QUEUE_BIT:0] CNT_FULL   = DEPTH[QUEUE_BIT:0];
   localparam logic [QUEUE_BIT:0] CNT_ALMOST = ALMOST[QUEUE_BIT:0];

   logic [31:0] res_val;
   logic        res_jump;
   logic [31:0] res_target;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] imm;
   logic [31:0] pc;
   logic [4:0]  shamt_r;
   logic [4:0]  shamt_i;

   assign a       = bus_if.val1;
   assign b       = bus_if.val2;
   assign imm     = bus_if.imm;
   assign pc      = bus_if.pc;
   assign shamt_r = b[4:0];
   assign shamt_i = imm[4:0];

   always_comb begin
      res_val    = '0;
      res_jump   = 1'b0;
      res_target = '0;
      case (bus_if.opt)
         OPT_LUI:   res_val = imm;
         OPT_AUIPC: res_val = pc + imm;
         OPT_JAL: begin
            res_val    = pc + 32'd4;
            res_jump   = 1'b1;
            res_target = pc + imm;
         end
         OPT_JALR: begin
            res_val    = pc + 32'd4;
            res_jump   = 1'b1;
            res_target = (a + imm) & ~32'd1;
         end
         OPT_BEQ: begin
            res_jump   = (a == b);
            res_target = pc + imm;
         end
         OPT_BNE: begin
            res_jump   = (a != b);
            res_target = pc + imm;
         end
         OPT_BLT: begin
            res_jump   = ($signed(a) < $signed(b));
            res_target = pc + imm;
         end
         OPT_BGE: begin
            res_jump   = ($signed(a) >= $signed(b));
            res_target = pc + imm;
         end
         OPT_BLTU: begin
            res_jump   = (a < b);
            res_target = pc + imm;
         end
         OPT_BGEU: begin
            res_jump   = (a >= b);
            res_target = pc + imm;
         end
         OPT_ADD:   res_val = a + b;
         OPT_SUB:   res_val = a - b;
         OPT_SLL:   res_val = a << shamt_r;
         OPT_SLT:   res_val = {31'd0, $signed(a) < $signed(b)};
         OPT_SLTU:  res_val = {31'd0, a < b};
         OPT_XOR:   res_val = a ^ b;
         OPT_SRL:   res_val = a >> shamt_r;
         OPT_SRA:   res_val = $unsigned($signed(a) >>> shamt_r);
         OPT_OR:    res_val = a | b;
         OPT_AND:   res_val = a & b;
         OPT_ADDI:  res_val = a + imm;
         OPT_SLTI:  res_val = {31'd0, $signed(a) < $signed(imm)};
         OPT_SLTIU: res_val = {31'd0, a < imm};
         OPT_XORI:  res_val = a ^ imm;
         OPT_ORI:   res_val = a | imm;
         OPT_ANDI:  res_val = a & imm;
         OPT_SLLI:  res_val = a << shamt_i;
         OPT_SRLI:  res_val = a >> shamt_i;
         OPT_SRAI:  res_val = $unsigned($signed(a) >>> shamt_i);
         default: begin
            res_val    = '0;
            res_jump   = 1'b0;
            res_target = '0;
         end
      endcase
   end

   logic [ROB_BIT-1:0]   src_q    [DEPTH];
   logic [31:0]          val_q    [DEPTH];
   logic                 jump_q   [DEPTH];
   logic [31:0]          target_q [DEPTH];
   logic [QUEUE_BIT-1:0] head_q, head_d;
   logic [QUEUE_BIT-1:0] tail_q, tail_d;
   logic [QUEUE_BIT:0]   count_q, count_d;
   logic                 ovf_q, ovf_d;

   logic head_valid;
   logic is_full;
   logic live;
   logic do_deq;
   logic do_enq;

   assign head_valid = (count_q != '0);
   assign is_full    = (count_q == CNT_FULL);
   assign live       = rdy_i & ~alu_rb_i;
   assign do_deq     = live & head_valid & bus_if.gnt;
   // A full queue may still accept when the head leaves on the same edge.
   assign do_enq     = live & bus_if.ena & (~is_full | do_deq);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (rdy_i) begin
         if (alu_rb_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (do_deq) head_d = head_q + 1'b1;
            if (do_enq) tail_d = tail_q + 1'b1;
            case ({do_enq, do_deq})
               2'b10:   count_d = count_q + 1'b1;
               2'b01:   count_d = count_q - 1'b1;
               default: count_d = count_q;
            endcase
            if (bus_if.ena && is_full && !do_deq) ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            src_q[i]    <= '0;
            val_q[i]    <= '0;
            jump_q[i]   <= 1'b0;
            target_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         if (do_enq) begin
            src_q[tail_q]    <= bus_if.rob_idx;
            val_q[tail_q]    <= res_val;
            jump_q[tail_q]   <= res_jump;
            target_q[tail_q] <= res_target;
         end
      end
   end

   // Head fields are masked so an idle channel presents all zeros.
   assign bus_if.valid  = head_valid;
   assign bus_if.src    = head_valid ? src_q[head_q]    : '0;
   assign bus_if.val    = head_valid ? val_q[head_q]    : '0;
   assign bus_if.jump   = head_valid ? jump_q[head_q]   : 1'b0;
   assign bus_if.target = head_valid ? target_q[head_q] : '0;
   assign bus_if.full   = (count_q >= CNT_ALMOST);
   assign alu_ovf_o     = ovf_q;

endmodule

// File: tb/tb_alu_cdb_stage.sv
// Directed bench for alu_cdb_stage: stimulus pushes expected CDB entries,
// a negedge monitor pops and compares each granted head.
module tb_alu_cdb_stage;
   import alu_cdb_stage_pkg::*;

   logic clk;
   logic rst_n;
   logic rdy;
   logic rb;
   logic ovf;

   alu_cdb_stage_if #(.ROB_BIT(4)) bus ();

   alu_cdb_stage #(.ROB_BIT(4), .QUEUE_BIT(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rdy_i    (rdy),
      .alu_rb_i (rb),
      .bus_if   (bus),
      .alu_ovf_o(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  src;
      logic [31:0] val;
      logic        jump;
      logic [31:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] im, input logic [31:0] p, input logic [3:0] tag,
                        input bit push, input logic [31:0] ev, input logic ej,
                        input logic [31:0] et);
      exp_t e;
      bus.ena     = 1'b1;
      bus.opt     = op;
      bus.val1    = v1;
      bus.val2    = v2;
      bus.imm     = im;
      bus.pc      = p;
      bus.rob_idx = tag;
      if (push) begin
         e.src = tag; e.val = ev; e.jump = ej; e.tgt = et;
         exp_q.push_back(e);
      end
      tick();
      bus.ena = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"},  {31'd0, bus.valid}, 32'd0);
      chk({tag, "_src"},    {28'd0, bus.src},   32'd0);
      chk({tag, "_val"},    bus.val,            32'd0);
      chk({tag, "_jump"},   {31'd0, bus.jump},  32'd0);
      chk({tag, "_target"}, bus.target,         32'd0);
      chk({tag, "_full"},   {31'd0, bus.full},  32'd0);
      chk({tag, "_ovf"},    {31'd0, ovf},       32'd0);
   endtask

   // Monitor: a head presented with grant while live leaves at the next edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rdy && !rb && bus.valid && bus.gnt) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_broadcast: got src %h val %h, expected none", bus.src, bus.val);
         end else begin
            e = exp_q.pop_front();
            chk("cdb_src",    {28'd0, bus.src},  {28'd0, e.src});
            chk("cdb_val",    bus.val,           e.val);
            chk("cdb_jump",   {31'd0, bus.jump}, {31'd0, e.jump});
            chk("cdb_target", bus.target,        e.tgt);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rdy = 1'b1; rb = 1'b0;
      bus.ena = 1'b0; bus.opt = OPT_NONE; bus.val1 = '0; bus.val2 = '0;
      bus.imm = '0; bus.pc = '0; bus.rob_idx = '0; bus.gnt = 1'b0;
      #2;
      chk_idle("reset");
      #10 rst_n = 1'b1;
      tick();

      // ADD with grant held: visible one cycle after issue, gone the next.
      bus.gnt = 1'b1;
      chk("t1_pre_valid", {31'd0, bus.valid}, 32'd0);
      issue(OPT_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 1, 32'd12, 1'b0, 32'd0);
      chk("t1_valid", {31'd0, bus.valid}, 32'd1);
      chk("t1_val",   bus.val,            32'd12);
      tick();
      chk("t1_valid_after", {31'd0, bus.valid}, 32'd0);

      issue(OPT_BLT,   32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd1, 1, 32'd0, 1'b1, 32'h120);
      issue(OPT_BLTU,  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd2, 1, 32'd0, 1'b0, 32'h120);
      issue(OPT_JALR,  32'h1003, 32'd0, 32'd4, 32'h40, 4'd3, 1, 32'h44, 1'b1, 32'h1006);
      issue(OPT_JAL,   32'd0, 32'd0, 32'hFFFF_FFF0, 32'h200, 4'd4, 1, 32'h204, 1'b1, 32'h1F0);
      issue(OPT_BEQ,   32'd7, 32'd7, 32'd8, 32'd0, 4'd5, 1, 32'd0, 1'b1, 32'd8);
      issue(OPT_SUB,   32'd3, 32'd5, 32'd0, 32'd0, 4'd6, 1, 32'hFFFF_FFFE, 1'b0, 32'd0);
      issue(OPT_SLT,   32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd7, 1, 32'd1, 1'b0, 32'd0);
      issue(OPT_SLTU,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd8, 1, 32'd0, 1'b0, 32'd0);
      issue(OPT_SRA,   32'h8000_0000, 32'h24, 32'd0, 32'd0, 4'd9, 1, 32'hF800_0000, 1'b0, 32'd0);
      issue(OPT_SRLI,  32'h8000_0000, 32'd0, 32'd4, 32'd0, 4'd10, 1, 32'h0800_0000, 1'b0, 32'd0);
      issue(OPT_SLLI,  32'd1, 32'd0, 32'd31, 32'd0, 4'd11, 1, 32'h8000_0000, 1'b0, 32'd0);
      issue(OPT_LUI,   32'd0, 32'd0, 32'h1234_5000, 32'd0, 4'd12, 1, 32'h1234_5000, 1'b0, 32'd0);
      issue(OPT_AUIPC, 32'd0, 32'd0, 32'h1000, 32'h100, 4'd13, 1, 32'h1100, 1'b0, 32'd0);
      issue(OPT_XORI,  32'hFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 4'd14, 1, 32'hFFFF_FF00, 1'b0, 32'd0);
      issue(OPT_SLTIU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0, 4'd15, 1, 32'd1, 1'b0, 32'd0);
      issue(6'h3F,     32'd9, 32'd9, 32'd9, 32'h80, 4'd1, 1, 32'd0, 1'b0, 32'd0);
      drain();

      // Fill without grant; a full queue with a same-edge dequeue is not an overflow.
      bus.gnt = 1'b0;
      issue(OPT_ADDI, 32'd1, 32'd0, 32'd1, 32'd0, 4'd1, 1, 32'd2, 1'b0, 32'd0);
      issue(OPT_ADDI, 32'd2, 32'd0, 32'd1, 32'd0, 4'd2, 1, 32'd3, 1'b0, 32'd0);
      chk("t4_full_at2", {31'd0, bus.full}, 32'd0);
      issue(OPT_ADDI, 32'd3, 32'd0, 32'd1, 32'd0, 4'd3, 1, 32'd4, 1'b0, 32'd0);
      chk("t4_full_at3", {31'd0, bus.full}, 32'd1);
      issue(OPT_ADDI, 32'd4, 32'd0, 32'd1, 32'd0, 4'd4, 1, 32'd5, 1'b0, 32'd0);
      chk("t4_ovf_at4", {31'd0, ovf}, 32'd0);
      bus.gnt = 1'b1;
      issue(OPT_ADDI, 32'd5, 32'd0, 32'd1, 32'd0, 4'd5, 1, 32'd6, 1'b0, 32'd0);
      chk("t4_ovf_enq_deq", {31'd0, ovf}, 32'd0);
      drain();
      chk("t4_full_drained", {31'd0, bus.full}, 32'd0);

      // Fifth issue into a full queue is dropped and flagged.
      bus.gnt = 1'b0;
      issue(OPT_OR, 32'h10, 32'h01, 32'd0, 32'd0, 4'd6, 1, 32'h11, 1'b0, 32'd0);
      issue(OPT_OR, 32'h20, 32'h02, 32'd0, 32'd0, 4'd7, 1, 32'h22, 1'b0, 32'd0);
      issue(OPT_OR, 32'h30, 32'h03, 32'd0, 32'd0, 4'd8, 1, 32'h33, 1'b0, 32'd0);
      issue(OPT_OR, 32'h40, 32'h04, 32'd0, 32'd0, 4'd9, 1, 32'h44, 1'b0, 32'd0);
      issue(OPT_OR, 32'h50, 32'h05, 32'd0, 32'd0, 4'd10, 0, 32'd0, 1'b0, 32'd0);
      chk("t4_ovf_set", {31'd0, ovf}, 32'd1);
      bus.gnt = 1'b1;
      drain();
      chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

      // Rollback with concurrent issue and grant.
      bus.gnt = 1'b0;
      issue(OPT_AND, 32'hF0, 32'h3C, 32'd0, 32'd0, 4'd1, 1, 32'h30, 1'b0, 32'd0);
      issue(OPT_AND, 32'h0F, 32'h3C, 32'd0, 32'd0, 4'd2, 1, 32'h0C, 1'b0, 32'd0);
      rb = 1'b1;
      bus.gnt = 1'b1;
      exp_q.delete();
      issue(OPT_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd3, 0, 32'd0, 1'b0, 32'd0);
      rb = 1'b0;
      bus.gnt = 1'b0;
      chk("t5_valid", {31'd0, bus.valid}, 32'd0);
      chk("t5_src",   {28'd0, bus.src},   32'd0);
      chk("t5_full",  {31'd0, bus.full},  32'd0);
      chk("t5_ovf_kept", {31'd0, ovf},    32'd1);
      tick();
      chk("t5_valid_later", {31'd0, bus.valid}, 32'd0);
      bus.gnt = 1'b1;
      issue(OPT_XOR, 32'hA5, 32'hFF, 32'd0, 32'd0, 4'd5, 1, 32'h5A, 1'b0, 32'd0);
      drain();

      // Freeze: head and state hold while rdy is low, even with grant and issue.
      bus.gnt = 1'b0;
      issue(OPT_ADDI, 32'h10, 32'd0, 32'h20, 32'd0, 4'd6, 1, 32'h30, 1'b0, 32'd0);
      rdy = 1'b0;
      bus.gnt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(OPT_SUB, 32'd9, 32'd1, 32'd0, 32'd0, 4'd7, 0, 32'd0, 1'b0, 32'd0);
         chk("t6_hold_valid", {31'd0, bus.valid}, 32'd1);
         chk("t6_hold_src",   {28'd0, bus.src},   32'd6);
         chk("t6_hold_val",   bus.val,            32'h30);
      end
      rdy = 1'b1;
      drain();
      tick();
      chk("t6_no_ghost", {31'd0, bus.valid}, 32'd0);

      // Asynchronous reset mid-cycle clears everything before the next edge.
      bus.gnt = 1'b0;
      issue(OPT_JAL, 32'd0, 32'd0, 32'd8, 32'h300, 4'd8, 1, 32'h304, 1'b1, 32'h308);
      chk("t6_pre_rst_valid", {31'd0, bus.valid}, 32'd1);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1 chk_idle("async_rst");
      #1 rst_n = 1'b1;
      tick();
      bus.gnt = 1'b1;
      issue(OPT_ADD, 32'd100, 32'd23, 32'd0, 32'd0, 4'd9, 1, 32'd123, 1'b0, 32'd0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
